// File: rtl/cva6_hpdcache_st_amo_buf_adapter_pkg.sv
// Shared types for the CVA6 <-> HPDcache store/AMO adapter: config, request/response
// structs, AMO FSM states and the CVA6-to-HPDcache AMO opcode mapping.
package cva6_hpdcache_adapter_pkg;

    localparam int unsigned OFFSET_W = 12;
    localparam int unsigned TAG_W    = 44;
    localparam int unsigned PADDR_W  = OFFSET_W + TAG_W;
    localparam int unsigned SID_W    = 3;
    localparam int unsigned TID_W    = 4;

    typedef struct packed {
        int unsigned xlen;
        logic [63:0] cached_base;
        logic [63:0] cached_size;
        logic [63:0] dspm_base;
        logic [63:0] dspm_size;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{
        xlen: 64,
        cached_base: 64'h8000_0000, cached_size: 64'h8000_0000,
        dspm_base: 64'h0, dspm_size: 64'h0
    };

    typedef enum logic [3:0] {
        AMO_NONE, AMO_LR, AMO_SC, AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR,
        AMO_XOR, AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU, AMO_CAS1, AMO_CAS2
    } amo_t;

    typedef enum logic [3:0] {
        HPDCACHE_REQ_LOAD, HPDCACHE_REQ_STORE, HPDCACHE_REQ_AMO_LR, HPDCACHE_REQ_AMO_SC,
        HPDCACHE_REQ_AMO_SWAP, HPDCACHE_REQ_AMO_ADD, HPDCACHE_REQ_AMO_AND, HPDCACHE_REQ_AMO_OR,
        HPDCACHE_REQ_AMO_XOR, HPDCACHE_REQ_AMO_MAX, HPDCACHE_REQ_AMO_MAXU,
        HPDCACHE_REQ_AMO_MIN, HPDCACHE_REQ_AMO_MINU
    } hpdcache_op_e;

    typedef enum logic [1:0] {IDLE, DRAIN, ISSUE, WAIT} amo_fsm_e;

    typedef struct packed {
        logic [TAG_W-1:0]    address_tag;
        logic [OFFSET_W-1:0] address_index;
        logic [63:0]         data_wdata;
        logic [7:0]          data_be;
        logic [1:0]          data_size;
    } dcache_req_i_t;

    typedef struct packed {
        logic        req;
        amo_t        amo_op;
        logic [1:0]  size;
        logic [63:0] operand_a;
        logic [63:0] operand_b;
    } amo_req_t;

    typedef struct packed {
        logic        ack;
        logic [63:0] result;
    } amo_resp_t;

    typedef struct packed {
        logic uncacheable;
        logic io;
    } hpdcache_pma_t;

    typedef struct packed {
        logic [OFFSET_W-1:0] addr_offset;
        logic [63:0]         wdata;
        hpdcache_op_e        op;
        logic [7:0]          be;
        logic [2:0]          size;
        logic [SID_W-1:0]    sid;
        logic [TID_W-1:0]    tid;
        logic                need_rsp;
        logic                phys_indexed;
        logic [TAG_W-1:0]    addr_tag;
        hpdcache_pma_t       pma;
    } hpdcache_req_t;

    typedef struct packed {
        logic [63:0]      rdata;
        logic [SID_W-1:0] sid;
        logic [TID_W-1:0] tid;
        logic             error;
    } hpdcache_rsp_t;

    typedef struct packed {
        logic [TAG_W-1:0]    addr_tag;
        logic [OFFSET_W-1:0] addr_offset;
        logic [63:0]         wdata;
        logic [7:0]          be;
        logic [1:0]          size;
    } st_fifo_entry_t;

    typedef struct packed {
        logic         mapped;
        hpdcache_op_e op;
    } amo_map_t;

    function automatic amo_map_t amo_op_to_hpdcache(amo_t op);
        amo_map_t m;
        m.mapped = 1'b1;
        m.op     = HPDCACHE_REQ_LOAD;
        case (op)
            AMO_LR:   m.op = HPDCACHE_REQ_AMO_LR;
            AMO_SC:   m.op = HPDCACHE_REQ_AMO_SC;
            AMO_SWAP: m.op = HPDCACHE_REQ_AMO_SWAP;
            AMO_ADD:  m.op = HPDCACHE_REQ_AMO_ADD;
            AMO_AND:  m.op = HPDCACHE_REQ_AMO_AND;
            AMO_OR:   m.op = HPDCACHE_REQ_AMO_OR;
            AMO_XOR:  m.op = HPDCACHE_REQ_AMO_XOR;
            AMO_MAX:  m.op = HPDCACHE_REQ_AMO_MAX;
            AMO_MAXU: m.op = HPDCACHE_REQ_AMO_MAXU;
            AMO_MIN:  m.op = HPDCACHE_REQ_AMO_MIN;
            AMO_MINU: m.op = HPDCACHE_REQ_AMO_MINU;
            default:  m.mapped = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic in_region(logic [63:0] base, logic [63:0] size,
                                       logic [PADDR_W-1:0] addr);
        logic [63:0] a = 64'(addr);
        return (size != 64'd0) && (a >= base) && ((a - base) < size);
    endfunction

    function automatic logic in_cacheable(cva6_cfg_t cfg, logic [PADDR_W-1:0] addr);
        return in_region(cfg.cached_base, cfg.cached_size, addr);
    endfunction

    function automatic logic in_dspm(cva6_cfg_t cfg, logic [PADDR_W-1:0] addr);
        return in_region(cfg.dspm_base, cfg.dspm_size, addr);
    endfunction

    function automatic logic [63:0] sext32(logic [31:0] w);
        return {{32{w[31]}}, w};
    endfunction

endpackage

// File: rtl/cva6_hpdcache_st_amo_buf_adapter_if.sv
// Store, AMO and HPDcache request/response signals of the adapter, grouped in one bundle.
interface cva6_hpdcache_st_amo_buf_adapter_if;
    import cva6_hpdcache_adapter_pkg::*;

    logic          st_valid;
    logic          st_ready;
    dcache_req_i_t st_req;
    logic          st_empty;
    amo_req_t      amo_req;
    amo_resp_t     amo_resp;
    logic          hpdcache_req_valid;
    logic          hpdcache_req_ready;
    hpdcache_req_t hpdcache_req;
    logic          hpdcache_rsp_valid;
    hpdcache_rsp_t hpdcache_rsp;

    modport slave (
        input  st_valid, st_req, amo_req, hpdcache_req_ready, hpdcache_rsp_valid, hpdcache_rsp,
        output st_ready, st_empty, amo_resp, hpdcache_req_valid, hpdcache_req
    );

    modport master (
        output st_valid, st_req, amo_req, hpdcache_req_ready, hpdcache_rsp_valid, hpdcache_rsp,
        input  st_ready, st_empty, amo_resp, hpdcache_req_valid, hpdcache_req
    );

endinterface

// File: rtl/cva6_hpdcache_st_fifo.sv
// Valid/ready FIFO of buffered stores; pointers carry an extra wrap bit for full/empty.
module cva6_hpdcache_st_fifo
    import cva6_hpdcache_adapter_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           push_valid,
    input  st_fifo_entry_t push_data,
    output logic           full,
    output logic           pop_valid,
    input  logic           pop_ready,
    output st_fifo_entry_t pop_data,
    output logic           empty
);

    localparam int unsigned PtrW = $clog2(Depth);

    st_fifo_entry_t  mem [Depth];
    logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
    logic            push, pop;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                       (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign push      = push_valid && !full;
    assign pop       = pop_ready && !empty;
    assign pop_valid = !empty;
    assign pop_data  = mem[rd_ptr_q[PtrW-1:0]];

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage has no reset; entries are only read once the pointers mark them valid.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q[PtrW-1:0]] <= push_data;
    end

endmodule

// File: rtl/cva6_hpdcache_st_amo_buf_adapter.sv
// Store/AMO port adapter: buffers core stores, orders AMOs behind them and returns the AMO result.
module cva6_hpdcache_st_amo_buf_adapter
    import cva6_hpdcache_adapter_pkg::*;
#(
    parameter cva6_cfg_t         CVA6Cfg     = cva6_cfg_empty,
    parameter int unsigned       StFifoDepth = 4,
    parameter logic [TID_W-1:0]  AmoTid      = '1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [SID_W-1:0]  hpdcache_req_sid_i,
    cva6_hpdcache_st_amo_buf_adapter_if.slave bus
);

    amo_fsm_e           state_q, state_d;
    amo_req_t           amo_q;
    amo_map_t           amo_map;
    st_fifo_entry_t     push_entry, head;
    logic               fifo_push, fifo_pop, fifo_valid, fifo_empty, fifo_full;
    logic               amo_ack;
    logic [63:0]        amo_result;
    logic [PADDR_W-1:0] req_addr;
    hpdcache_req_t      req;
    logic               unused_bits;

    assign push_entry = '{addr_tag: bus.st_req.address_tag, addr_offset: bus.st_req.address_index,
                          wdata: bus.st_req.data_wdata, be: bus.st_req.data_be,
                          size: bus.st_req.data_size};

    // Stores are blocked while an AMO is being ordered, issued or awaited.
    assign bus.st_ready = !fifo_full && (state_q == IDLE);
    assign bus.st_empty = fifo_empty;
    assign fifo_push    = bus.st_valid && bus.st_ready;
    assign fifo_pop     = (state_q != ISSUE) && bus.hpdcache_req_ready;

    cva6_hpdcache_st_fifo #(.Depth(StFifoDepth)) st_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_valid (fifo_push),
        .push_data  (push_entry),
        .full       (fifo_full),
        .pop_valid  (fifo_valid),
        .pop_ready  (fifo_pop),
        .pop_data   (head),
        .empty      (fifo_empty)
    );

    assign amo_map = amo_op_to_hpdcache(amo_q.amo_op);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            amo_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.amo_req.req) amo_q <= bus.amo_req;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        amo_ack    = 1'b0;
        amo_result = '0;
        case (state_q)
            IDLE:  if (bus.amo_req.req) state_d = DRAIN;
            DRAIN: if (fifo_empty) begin
                if (amo_map.mapped) begin
                    state_d = ISSUE;
                end else begin
                    amo_ack = 1'b1;
                    state_d = IDLE;
                end
            end
            ISSUE: if (bus.hpdcache_req_ready) state_d = WAIT;
            WAIT:  if (bus.hpdcache_rsp_valid && bus.hpdcache_rsp.tid == AmoTid) begin
                amo_ack = 1'b1;
                state_d = IDLE;
                if (CVA6Cfg.xlen == 32)
                    amo_result = sext32(bus.hpdcache_rsp.rdata[31:0]);
                else if (amo_q.size == 2'b10)
                    amo_result = sext32(amo_q.operand_a[2] ? bus.hpdcache_rsp.rdata[63:32]
                                                           : bus.hpdcache_rsp.rdata[31:0]);
                else
                    amo_result = bus.hpdcache_rsp.rdata;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req              = '0;
        req.sid          = hpdcache_req_sid_i;
        req.phys_indexed = 1'b1;
        if (state_q == ISSUE) begin
            req_addr     = amo_q.operand_a[PADDR_W-1:0];
            req.op       = amo_map.op;
            req.tid      = AmoTid;
            req.need_rsp = 1'b1;
            req.size     = {1'b0, amo_q.size};
            if (CVA6Cfg.xlen == 32) begin
                req.be    = 8'h0F;
                req.wdata = {32'b0, amo_q.operand_b[31:0]};
            end else if (amo_q.size == 2'b10) begin
                req.be    = amo_q.operand_a[2] ? 8'hF0 : 8'h0F;
                req.wdata = {2{amo_q.operand_b[31:0]}};
            end else begin
                req.be    = 8'hFF;
                req.wdata = amo_q.operand_b;
            end
        end else begin
            req_addr  = {head.addr_tag, head.addr_offset};
            req.op    = HPDCACHE_REQ_STORE;
            req.wdata = head.wdata;
            req.be    = head.be;
            req.size  = {1'b0, head.size};
        end
        req.addr_offset     = req_addr[OFFSET_W-1:0];
        req.addr_tag        = req_addr[PADDR_W-1:OFFSET_W];
        req.pma.uncacheable = !in_cacheable(CVA6Cfg, req_addr) && !in_dspm(CVA6Cfg, req_addr);
    end

    assign bus.hpdcache_req_valid = (state_q == ISSUE) || fifo_valid;
    assign bus.hpdcache_req       = req;
    assign bus.amo_resp           = '{ack: amo_ack, result: amo_result};

    assign unused_bits = ^{amo_q.req, amo_q.operand_a[63:PADDR_W],
                           bus.hpdcache_rsp.sid, bus.hpdcache_rsp.error};

    // Only the AMO ever expects a response; anything else on the response port is a protocol error.
    rsp_tid_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.hpdcache_rsp_valid |-> bus.hpdcache_rsp.tid == AmoTid);

    amo_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q != IDLE) |-> bus.amo_req.req);

endmodule

// File: tb/tb_cva6_hpdcache_st_amo_buf_adapter.sv
// Self-checking bench: vector tables for stores and AMOs, scoreboard queues for cache requests and acks.
module tb_cva6_hpdcache_st_amo_buf_adapter;
    import cva6_hpdcache_adapter_pkg::*;

    localparam logic [TID_W-1:0] AMO_TID = '1;
    localparam logic [SID_W-1:0] SID     = 3'd5;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    cva6_hpdcache_st_amo_buf_adapter_if bus();

    cva6_hpdcache_st_amo_buf_adapter #(.StFifoDepth(4), .AmoTid(AMO_TID)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .hpdcache_req_sid_i (SID),
        .bus                (bus)
    );

    typedef struct {
        hpdcache_op_e       op;
        logic [TID_W-1:0]   tid;
        logic               need_rsp;
        logic [PADDR_W-1:0] addr;
        logic [63:0]        wdata;
        logic [7:0]         be;
        logic               uncacheable;
    } exp_req_t;

    typedef struct {
        logic [PADDR_W-1:0] addr;
        logic [63:0]        data;
        logic [7:0]         be;
        logic [1:0]         size;
        logic               exp_uncached;
    } st_vec_t;

    typedef struct {
        amo_t         op;
        logic [1:0]   size;
        logic [63:0]  opa, opb, rdata;
        logic         mapped;
        hpdcache_op_e exp_op;
        logic [7:0]   exp_be;
        logic [63:0]  exp_wdata, exp_result;
        logic         exp_uncached;
    } amo_vec_t;

    exp_req_t    exp_reqs[$];
    logic [63:0] exp_acks[$];
    int          n_checks = 0;
    int          n_errors = 0;

    st_vec_t  st_vecs[5];
    st_vec_t  bp_vecs[6];
    amo_vec_t amo_vecs[5];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard: compare every accepted cache request and every AMO ack against the queues.
    always @(negedge clk) begin
        exp_req_t e;
        if (rst_ni && bus.hpdcache_req_valid && bus.hpdcache_req_ready) begin
            check("req_expected", 64'(exp_reqs.size() != 0), 64'd1);
            if (exp_reqs.size() != 0) begin
                e = exp_reqs.pop_front();
                check("req_op", bus.hpdcache_req.op, e.op);
                check("req_tid", bus.hpdcache_req.tid, e.tid);
                check("req_need_rsp", bus.hpdcache_req.need_rsp, e.need_rsp);
                check("req_addr", {bus.hpdcache_req.addr_tag, bus.hpdcache_req.addr_offset}, e.addr);
                check("req_wdata", bus.hpdcache_req.wdata, e.wdata);
                check("req_be", bus.hpdcache_req.be, e.be);
                check("req_uncacheable", bus.hpdcache_req.pma.uncacheable, e.uncacheable);
                check("req_sid", bus.hpdcache_req.sid, SID);
                check("req_phys_indexed", bus.hpdcache_req.phys_indexed, 1'b1);
            end
        end
        if (rst_ni && bus.amo_resp.ack) begin
            check("ack_expected", 64'(exp_acks.size() != 0), 64'd1);
            if (exp_acks.size() != 0) check("amo_result", bus.amo_resp.result, exp_acks.pop_front());
        end
    end

    task automatic drive_store(input st_vec_t v, input int budget, output logic accepted);
        accepted = 1'b0;
        bus.st_valid = 1'b1;
        bus.st_req = '{address_tag: v.addr[PADDR_W-1:OFFSET_W], address_index: v.addr[OFFSET_W-1:0],
                       data_wdata: v.data, data_be: v.be, data_size: v.size};
        for (int i = 0; i < budget && !accepted; i++) begin
            @(negedge clk);
            if (bus.st_ready) begin
                accepted = 1'b1;
                exp_reqs.push_back('{op: HPDCACHE_REQ_STORE, tid: '0, need_rsp: 1'b0, addr: v.addr,
                                     wdata: v.data, be: v.be, uncacheable: v.exp_uncached});
            end
            @(posedge clk); #1;
        end
        bus.st_valid = 1'b0;
    endtask

    task automatic wait_drained(input string name);
        logic ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = bus.st_empty && !bus.hpdcache_req_valid && exp_reqs.size() == 0;
        end
        check(name, ok, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic do_amo(input amo_vec_t v, input logic with_store, input st_vec_t sv);
        logic rsp_due = 1'b0;
        logic done = 1'b0;
        int   ack_cycle = -1;
        if (with_store) begin
            bus.st_valid = 1'b1;
            bus.st_req = '{address_tag: sv.addr[PADDR_W-1:OFFSET_W], address_index: sv.addr[OFFSET_W-1:0],
                           data_wdata: sv.data, data_be: sv.be, data_size: sv.size};
            exp_reqs.push_back('{op: HPDCACHE_REQ_STORE, tid: '0, need_rsp: 1'b0, addr: sv.addr,
                                 wdata: sv.data, be: sv.be, uncacheable: sv.exp_uncached});
        end
        if (v.mapped)
            exp_reqs.push_back('{op: v.exp_op, tid: AMO_TID, need_rsp: 1'b1, addr: v.opa[PADDR_W-1:0],
                                 wdata: v.exp_wdata, be: v.exp_be, uncacheable: v.exp_uncached});
        exp_acks.push_back(v.exp_result);
        bus.amo_req = '{req: 1'b1, amo_op: v.op, size: v.size, operand_a: v.opa, operand_b: v.opb};
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (i == 0 && with_store) check("store_with_amo_ready", bus.st_ready, 1'b1);
            if (i == 1) check("st_ready_blocked_by_amo", bus.st_ready, 1'b0);
            if (bus.amo_resp.ack) begin
                done = 1'b1;
                ack_cycle = i;
            end else if (bus.hpdcache_req_valid && bus.hpdcache_req_ready &&
                         bus.hpdcache_req.op != HPDCACHE_REQ_STORE) begin
                rsp_due = 1'b1;
            end
            @(posedge clk); #1;
            bus.st_valid = 1'b0;
            if (i == 2) bus.hpdcache_req_ready = 1'b1;
            if (rsp_due && !done) begin
                bus.hpdcache_rsp_valid = 1'b1;
                bus.hpdcache_rsp = '{rdata: v.rdata, sid: SID, tid: AMO_TID, error: 1'b0};
                rsp_due = 1'b0;
            end else begin
                bus.hpdcache_rsp_valid = 1'b0;
            end
        end
        bus.amo_req.req = 1'b0;
        bus.hpdcache_rsp_valid = 1'b0;
        check("amo_ack_seen", done, 1'b1);
        if (!v.mapped) check("amo_unmapped_ack_latency", 64'(ack_cycle), 64'd1);
        @(negedge clk);
        check("amo_ack_single_pulse", bus.amo_resp.ack, 1'b0);
        check("amo_back_to_idle", bus.st_ready, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   n_acc;

        st_vecs[0] = '{56'h0000_8000_0010, 64'hDEAD,                  8'hFF, 2'd3, 1'b0};
        st_vecs[1] = '{56'h0000_0000_1000, 64'h1122_3344_5566_7788,   8'h0F, 2'd2, 1'b1};
        st_vecs[2] = '{56'h0000_FFFF_FFF8, 64'hA5A5_A5A5_A5A5_A5A5,   8'hC0, 2'd1, 1'b0};
        st_vecs[3] = '{56'h0001_0000_0000, 64'h1,                     8'h01, 2'd0, 1'b1};
        st_vecs[4] = '{56'h0000_7FFF_FFF8, 64'hCAFE_F00D_0000_0001,   8'hFF, 2'd3, 1'b1};
        for (int i = 0; i < 6; i++)
            bp_vecs[i] = '{56'h8000_0100 + 56'(i * 8), 64'h1000 + 64'(i), 8'hFF, 2'd3, 1'b0};
        amo_vecs[0] = '{AMO_ADD, 2'b11, 64'h8000_0100, 64'd5, 64'd5, 1'b1,
                        HPDCACHE_REQ_AMO_ADD, 8'hFF, 64'd5, 64'd5, 1'b0};
        amo_vecs[1] = '{AMO_SWAP, 2'b10, 64'h8000_0104, 64'h1234_5678, 64'h8000_0000_0000_0000, 1'b1,
                        HPDCACHE_REQ_AMO_SWAP, 8'hF0, 64'h1234_5678_1234_5678, 64'hFFFF_FFFF_8000_0000, 1'b0};
        amo_vecs[2] = '{AMO_OR, 2'b10, 64'h8000_0200, 64'hAAAA_5555_FFFF_0001, 64'h1234_5678_9ABC_DEF0, 1'b1,
                        HPDCACHE_REQ_AMO_OR, 8'h0F, 64'hFFFF_0001_FFFF_0001, 64'hFFFF_FFFF_9ABC_DEF0, 1'b0};
        amo_vecs[3] = '{AMO_MAXU, 2'b10, 64'h0000_2004, 64'd7, 64'h7FFF_FFFF_0000_0000, 1'b1,
                        HPDCACHE_REQ_AMO_MAXU, 8'hF0, 64'h0000_0007_0000_0007, 64'h0000_0000_7FFF_FFFF, 1'b1};
        amo_vecs[4] = '{AMO_NONE, 2'b11, 64'h8000_0300, 64'd9, 64'd0, 1'b0,
                        HPDCACHE_REQ_LOAD, 8'h00, 64'd0, 64'd0, 1'b0};

        bus.st_valid = 1'b0;
        bus.st_req = '0;
        bus.amo_req = '0;
        bus.hpdcache_req_ready = 1'b0;
        bus.hpdcache_rsp_valid = 1'b0;
        bus.hpdcache_rsp = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_st_ready", bus.st_ready, 1'b1);
        check("reset_st_empty", bus.st_empty, 1'b1);
        check("reset_req_valid", bus.hpdcache_req_valid, 1'b0);
        check("reset_amo_ack", bus.amo_resp.ack, 1'b0);
        @(posedge clk); #1;
        rst_ni = 1'b1;

        // Single store: valid appears the cycle after acceptance.
        bus.hpdcache_req_ready = 1'b1;
        drive_store(st_vecs[0], 1, acc);
        check("store0_accepted", acc, 1'b1);
        @(negedge clk);
        check("store0_valid_next_cycle", bus.hpdcache_req_valid, 1'b1);
        check("store0_in_flight_not_empty", bus.st_empty, 1'b0);
        @(posedge clk); #1;
        wait_drained("store0_drained");

        for (int i = 1; i < 5; i++) begin
            drive_store(st_vecs[i], 5, acc);
            check("table_store_accepted", acc, 1'b1);
        end
        wait_drained("table_stores_drained");

        // Back-pressure: only Depth stores fit, head stays stable while stalled.
        bus.hpdcache_req_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive_store(bp_vecs[i], 3, acc);
            if (acc) n_acc++;
        end
        check("bp_accepted_count", 64'(n_acc), 64'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_full_not_ready", bus.st_ready, 1'b0);
            check("bp_valid_held", bus.hpdcache_req_valid, 1'b1);
            check("bp_head_stable", bus.hpdcache_req.wdata, bp_vecs[0].data);
            @(posedge clk); #1;
        end
        bus.hpdcache_req_ready = 1'b1;
        bus.st_valid = 1'b1;
        @(negedge clk);
        check("full_pop_same_cycle_not_ready", bus.st_ready, 1'b0);
        @(posedge clk); #1;
        bus.st_valid = 1'b0;
        wait_drained("bp_drained_in_order");

        // AMO queued behind three stores, released only after the AMO has been raised.
        bus.hpdcache_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_store(st_vecs[i], 3, acc);
            check("pre_amo_store_accepted", acc, 1'b1);
        end
        do_amo(amo_vecs[0], 1'b0, st_vecs[0]);
        for (int k = 1; k < 5; k++) do_amo(amo_vecs[k], k == 1, st_vecs[3]);
        wait_drained("amo_table_drained");

        // Reset while the AMO waits for its response.
        exp_reqs.push_back('{op: HPDCACHE_REQ_AMO_ADD, tid: AMO_TID, need_rsp: 1'b1,
                             addr: amo_vecs[0].opa[PADDR_W-1:0], wdata: amo_vecs[0].exp_wdata,
                             be: 8'hFF, uncacheable: 1'b0});
        bus.amo_req = '{req: 1'b1, amo_op: AMO_ADD, size: 2'b11, operand_a: amo_vecs[0].opa,
                        operand_b: amo_vecs[0].opb};
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = bus.hpdcache_req_valid && bus.hpdcache_req.op == HPDCACHE_REQ_AMO_ADD;
            @(posedge clk); #1;
        end
        check("reset_test_amo_issued", acc, 1'b1);
        rst_ni = 1'b0;
        bus.amo_req = '0;
        @(negedge clk);
        check("midamo_reset_st_ready", bus.st_ready, 1'b1);
        check("midamo_reset_st_empty", bus.st_empty, 1'b1);
        check("midamo_reset_req_valid", bus.hpdcache_req_valid, 1'b0);
        check("midamo_reset_ack", bus.amo_resp.ack, 1'b0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        drive_store(st_vecs[1], 3, acc);
        check("post_reset_store_accepted", acc, 1'b1);
        wait_drained("post_reset_drained");

        check("req_queue_empty", 64'(exp_reqs.size()), 64'd0);
        check("ack_queue_empty", 64'(exp_acks.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
